// File: rtl/gem_axis_ext_fifo_tx.sv
// gem_axis_ext_fifo_tx: feeds whole AXI-Stream frames to the ZynqMP GEM external TX FIFO port
// and runs the end-of-frame toggle handshake that returns TX status.
module gem_axis_ext_fifo_tx #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tid,
  input  logic                 s_axis_tdest,
  input  logic                 s_axis_tuser,
  output logic [7:0]           gem_data,
  output logic                 gem_data_ready,
  output logic                 gem_data_valid,
  input  logic                 gem_data_rd_request,
  output logic                 gem_sop,
  output logic                 gem_eop,
  output logic                 gem_err,
  output logic                 gem_underflow,
  output logic                 gem_control,
  output logic                 gem_dma_tx_status_tog,
  input  logic                 gem_dma_tx_end_tog,
  input  logic [3:0]           gem_status,
  output logic [3:0]           status_last,
  output logic                 status_frame_done,
  output logic [CNT_WIDTH-1:0] frame_count
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, WAIT_END} state_t;
  state_t r_state, w_next;
  logic [7:0] r_data;
  logic r_valid, r_sop, r_eop, r_err, r_unf;
  logic r_end_q, r_pend, r_tog, r_done;
  logic [3:0] r_status;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic w_acc, w_dry, w_edge, w_consume, w_unused;
  assign w_acc     = (r_state == IDLE || r_state == XFER) && gem_data_rd_request && s_axis_tvalid;
  assign w_dry     = r_state == XFER && gem_data_rd_request && !s_axis_tvalid;
  assign w_edge    = gem_dma_tx_end_tog ^ r_end_q;
  assign w_consume = r_state == WAIT_END && r_pend;
  assign w_unused  = s_axis_tkeep ^ s_axis_tid ^ s_axis_tdest;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE || r_state == XFER)
      w_next = w_acc ? (s_axis_tlast ? WAIT_END : XFER) : (w_dry ? DRAIN : r_state);
    else if (r_state == DRAIN)
      w_next = s_axis_tvalid && s_axis_tlast ? WAIT_END : DRAIN;
    else
      w_next = r_pend ? IDLE : WAIT_END;
  end
  // Handshake outputs are combinational; held low while reset is asserted.
  always_comb begin
    s_axis_tready  = !rst && (r_state == DRAIN || w_acc);
    gem_data_ready = !rst && (r_state == XFER || (r_state == IDLE && s_axis_tvalid));
    gem_control    = w_unused & 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_err    <= 1'b0;
      r_unf    <= 1'b0;
      r_end_q  <= 1'b0;
      r_pend   <= 1'b0;
      r_tog    <= 1'b0;
      r_done   <= 1'b0;
      r_status <= '0;
      r_cnt    <= '0;
    end else begin
      r_valid <= w_acc || w_dry;
      r_sop   <= w_acc && r_state == IDLE;
      r_eop   <= w_acc && s_axis_tlast;
      r_err   <= w_acc && s_axis_tlast && s_axis_tuser;
      r_unf   <= w_dry;
      if (w_acc) r_data <= s_axis_tdata;
      r_end_q <= gem_dma_tx_end_tog;
      r_pend  <= w_edge || (r_pend && !w_consume);
      r_done  <= w_consume;
      if (w_consume) begin
        r_status <= gem_status;
        r_tog    <= ~r_tog;
        r_cnt    <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end
  assign gem_data              = r_data;
  assign gem_data_valid        = r_valid;
  assign gem_sop               = r_sop;
  assign gem_eop               = r_eop;
  assign gem_err               = r_err;
  assign gem_underflow         = r_unf;
  assign gem_dma_tx_status_tog = r_tog;
  assign status_last           = r_status;
  assign status_frame_done     = r_done;
  assign frame_count           = r_cnt;
endmodule

// File: tb/tb_gem_axis_ext_fifo_tx.sv
// tb_gem_axis_ext_fifo_tx: randomized frame traffic checked against a frame-level model of
// the expected GEM byte stream, status latching and frame counting.
module tb_gem_axis_ext_fifo_tx;
  localparam int CW = 3;
  logic clk = 0, rst = 1;
  logic [7:0] s_axis_tdata = 0;
  logic s_axis_tkeep = 0, s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic s_axis_tid = 0, s_axis_tdest = 0, s_axis_tuser = 0;
  logic [7:0] gem_data;
  logic gem_data_ready, gem_data_valid, gem_data_rd_request = 0;
  logic gem_sop, gem_eop, gem_err, gem_underflow, gem_control;
  logic gem_dma_tx_status_tog, gem_dma_tx_end_tog = 0;
  logic [3:0] gem_status = 0, status_last;
  logic status_frame_done;
  logic [CW-1:0] frame_count;

  gem_axis_ext_fifo_tx #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .gem_data(gem_data), .gem_data_ready(gem_data_ready), .gem_data_valid(gem_data_valid),
    .gem_data_rd_request(gem_data_rd_request), .gem_sop(gem_sop), .gem_eop(gem_eop),
    .gem_err(gem_err), .gem_underflow(gem_underflow), .gem_control(gem_control),
    .gem_dma_tx_status_tog(gem_dma_tx_status_tog), .gem_dma_tx_end_tog(gem_dma_tx_end_tog),
    .gem_status(gem_status), .status_last(status_last), .status_frame_done(status_frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic sop, eop, err, unf;} beat_t;
  logic [9:0] src_q[$];
  beat_t act_q[$], exp_q[$];
  bit src_en, draining, last_ready;
  int n_chk, n_fail, done_seen, popped, exp_cnt, exp_tog;

  task automatic tick(input bit rd);
    logic hs;
    logic [9:0] h;
    gem_data_rd_request = rd;
    h = src_q.size() > 0 ? src_q[0] : 10'd0;
    s_axis_tvalid = src_en && src_q.size() > 0;
    {s_axis_tuser, s_axis_tlast, s_axis_tdata} = h;
    {s_axis_tkeep, s_axis_tid, s_axis_tdest} = 3'($urandom);
    #1;
    last_ready = gem_data_ready;
    if (draining && s_axis_tvalid) begin
      n_chk++;
      if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL drain_tready: got %b want 1", s_axis_tready); end
    end
    hs = s_axis_tready && s_axis_tvalid;
    @(posedge clk);
    if (hs) begin
      if (draining && h[8]) draining = 0;
      void'(src_q.pop_front());
      popped++;
    end
    #1;
    if (gem_data_valid) begin
      n_chk++;
      if (!rd) begin n_fail++; $display("FAIL valid_latency: valid=1 without request in previous cycle"); end
      act_q.push_back({gem_data, gem_sop, gem_eop, gem_err, gem_underflow});
      if (gem_underflow) draining = 1;
    end
    if (status_frame_done) done_seen++;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b[$], input bit user, input int uf_k, input bit early,
                           input logic [3:0] st, input string nm);
    beat_t e;
    int cyc, eop_cyc, wait_n, nb;
    bit ended, was_ended, rdy_chk, toggled, uf_seen;
    act_q.delete(); exp_q.delete();
    done_seen = 0; popped = 0; draining = 0;
    foreach (b[i]) src_q.push_back({1'(user && i == b.size() - 1), 1'(i == b.size() - 1), b[i]});
    nb = uf_k > 0 ? uf_k : b.size();
    for (int i = 0; i < nb; i++) begin
      e.d = b[i]; e.sop = (i == 0); e.eop = (uf_k == 0 && i == nb - 1);
      e.err = e.eop && user; e.unf = 0;
      exp_q.push_back(e);
    end
    if (uf_k > 0) begin e = '0; e.unf = 1; exp_q.push_back(e); end
    gem_status = st;
    src_en = 1;
    tick(0);
    n_chk++;
    if (last_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_idle: got %b want 1", nm, last_ready); end
    ended = 0; rdy_chk = 0; toggled = 0; uf_seen = 0; eop_cyc = -1; cyc = 0;
    wait_n = $urandom_range(0, 4);
    while (done_seen == 0 && cyc < 300) begin
      src_en = !(uf_k > 0 && !uf_seen && popped >= uf_k);
      if (early && !toggled && act_q.size() > 0) begin
        gem_dma_tx_end_tog = ~gem_dma_tx_end_tog; toggled = 1;
      end else if (!early && !toggled && ended) begin
        if (wait_n == 0) begin gem_dma_tx_end_tog = ~gem_dma_tx_end_tog; toggled = 1; end
        else wait_n--;
      end
      was_ended = ended;
      tick($urandom_range(0, 3) != 0);
      cyc++;
      if (was_ended && !rdy_chk) begin
        rdy_chk = 1; n_chk++;
        if (last_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_wait_end: got %b want 0", nm, last_ready); end
      end
      if (act_q.size() > 0 && act_q[$].unf) uf_seen = 1;
      if (!ended && ((act_q.size() > 0 && act_q[$].eop) || (uf_seen && !draining && src_q.size() == 0))) begin
        ended = 1; eop_cyc = cyc;
      end
    end
    n_chk++;
    if (done_seen != 1) begin n_fail++; $display("FAIL %s frame_done: got %0d pulses want 1 (cycles %0d)", nm, done_seen, cyc); end
    n_chk++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s beat_count: got %0d want %0d", nm, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if ({act_q[i].sop, act_q[i].eop, act_q[i].err, act_q[i].unf} !== {exp_q[i].sop, exp_q[i].eop, exp_q[i].err, exp_q[i].unf}
          || (!exp_q[i].unf && act_q[i].d !== exp_q[i].d)) begin
        n_fail++;
        $display("FAIL %s beat%0d: got d=%h s/e/err/u=%b%b%b%b want d=%h s/e/err/u=%b%b%b%b", nm, i,
                 act_q[i].d, act_q[i].sop, act_q[i].eop, act_q[i].err, act_q[i].unf,
                 exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].err, exp_q[i].unf);
      end
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    exp_tog ^= 1;
    n_chk++;
    if (status_last !== st) begin n_fail++; $display("FAIL %s status_last: got %h want %h", nm, status_last, st); end
    n_chk++;
    if (gem_dma_tx_status_tog !== 1'(exp_tog)) begin n_fail++; $display("FAIL %s status_tog: got %b want %0d", nm, gem_dma_tx_status_tog, exp_tog); end
    n_chk++;
    if (frame_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL %s frame_count: got %0d want %0d", nm, frame_count, exp_cnt); end
    if (early) begin
      n_chk++;
      if (cyc - eop_cyc != 1) begin n_fail++; $display("FAIL %s early_toggle_wait: got %0d cycles want 1", nm, cyc - eop_cyc); end
    end
    tick(0);
    n_chk++;
    if (done_seen != 1) begin n_fail++; $display("FAIL %s done_pulse_width: got %0d pulses want 1", nm, done_seen); end
  endtask

  task automatic check_all_zero(input string nm);
    n_chk++;
    if ({gem_data, gem_data_valid, gem_sop, gem_eop, gem_err, gem_underflow, gem_data_ready, s_axis_tready,
         gem_control, gem_dma_tx_status_tog, status_last, status_frame_done, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got data=%h v=%b s=%b e=%b err=%b u=%b rdy=%b trdy=%b ctl=%b tog=%b st=%h done=%b cnt=%0d want all 0",
               nm, gem_data, gem_data_valid, gem_sop, gem_eop, gem_err, gem_underflow, gem_data_ready,
               s_axis_tready, gem_control, gem_dma_tx_status_tog, status_last, status_frame_done, frame_count);
    end
  endtask

  task automatic test_por();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    run_frame('{8'h11, 8'h22, 8'h33}, 0, 0, 0, 4'h5, "normal");
  endtask

  task automatic test_reset_mid_xfer();
    for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 1'(i == 3), 8'($urandom)});
    src_en = 1;
    tick(1); tick(1);
    n_chk++;
    if (frame_count !== CW'(1)) begin n_fail++; $display("FAIL reset_pre_count: got %0d want 1", frame_count); end
    rst = 1;
    #1;
    check_all_zero("reset_mid_xfer");
    src_q.delete(); act_q.delete();
    gem_dma_tx_end_tog = 0; gem_data_rd_request = 0; s_axis_tvalid = 0;
    exp_cnt = 0; exp_tog = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_bad_frame();
    run_frame('{8'($urandom), 8'($urandom)}, 1, 0, 0, 4'hA, "bad_frame");
  endtask

  task automatic test_underflow();
    run_frame('{8'hA1, 8'hA2, 8'hA3, 8'hA4}, 0, 1, 0, 4'h3, "underflow");
  endtask

  task automatic test_single_byte();
    run_frame('{8'h5C}, 0, 0, 0, 4'hC, "single_byte");
  endtask

  task automatic test_early_toggle();
    run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 0, 0, 1, 4'h9, "early_toggle");
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int n, k;
    bit early;
    for (int f = 0; f < 10; f++) begin
      b.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      k = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      early = n >= 2 && k == 0 && $urandom_range(0, 1) == 1;
      run_frame(b, 1'($urandom), k, early, 4'($urandom), "random");
    end
  endtask

  initial begin
    test_por();
    test_normal();
    test_reset_mid_xfer();
    test_bad_frame();
    test_underflow();
    test_single_byte();
    test_early_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gem_axis_ext_fifo_tx.md
Name: gem_axis_ext_fifo_tx

Overview:
Bridge from an 8-bit AXI-Stream frame source to the Xilinx ZynqMP GEM external-FIFO transmit interface. The upstream source is a store-and-forward frame FIFO, so tvalid implies a complete frame is buffered. The block presents bytes to the GEM on request and marks start, end, error and underflow. It then runs the end-of-frame toggle handshake and exposes the returned TX status.

Parameters:
CNT_WIDTH, 16, width of the transmitted-frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
s_axis_tdata  in  8  frame byte
s_axis_tkeep  in  1  ignored
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  byte accepted
s_axis_tlast  in  1  last byte of frame
s_axis_tid  in  1  ignored
s_axis_tdest  in  1  ignored
s_axis_tuser  in  1  bad-frame flag, sampled with tlast
gem_data  out  8  byte to GEM
gem_data_ready  out  1  frame data available to GEM
gem_data_valid  out  1  gem_data valid (reply to read request)
gem_data_rd_request  in  1  GEM byte read strobe, one byte per high cycle
gem_sop  out  1  first byte of frame
gem_eop  out  1  last byte of frame
gem_err  out  1  frame error, with eop
gem_underflow  out  1  source ran dry mid-frame
gem_control  out  1  per-frame control, constant 0
gem_dma_tx_status_tog  out  1  toggled when TX status is consumed
gem_dma_tx_end_tog  in  1  GEM toggles at end of frame transmission
gem_status  in  4  GEM TX status, valid at end toggle
status_last  out  4  latched gem_status of last frame
status_frame_done  out  1  one-cycle pulse per completed frame
frame_count  out  CNT_WIDTH  completed frames, wraps

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including gem_data, counters, status_tog, end-toggle sampler and pending flag.
- The GEM output registers are gem_data, valid, sop, eop, err and underflow. By default they are 0 each cycle, except gem_data, which holds its value.
- FSM states: IDLE, XFER, DRAIN, WAIT_END.
- s_axis_tready is combinational. It is 1 when rd_request and s_axis_tvalid are both high and state is IDLE or XFER. It is 1 unconditionally in DRAIN.
- gem_data_ready:
  - IDLE: equals s_axis_tvalid.
  - XFER: held 1.
  - DRAIN and WAIT_END: 0.
- IDLE, rd_request with tvalid: accept the byte. Next cycle valid=1, sop=1, data=tdata. If tlast is also set, then eop=1 and err=tuser in the same cycle, and go to WAIT_END. Otherwise go to XFER.
- IDLE, rd_request without tvalid: ignored.
- XFER, rd_request with tvalid: accept the byte; valid=1 next cycle, i.e. latency 1 cycle from rd_request. On tlast, eop=1 and err=tuser, and go to WAIT_END.
- XFER, rd_request without tvalid: next cycle valid=1 and underflow=1, then go to DRAIN.
- DRAIN: discard bytes until a byte with tlast is accepted, then go to WAIT_END. Discarded bytes produce no gem_data_valid.
- rd_request in DRAIN or WAIT_END: ignored.
- End-toggle detection:
  - gem_dma_tx_end_tog is sampled every cycle; any change sets a pending flag, including an edge arriving before WAIT_END is reached.
  - WAIT_END with pending set: clear pending, latch gem_status into status_last, invert gem_dma_tx_status_tog, pulse status_frame_done, increment frame_count (wraps at 2^CNT_WIDTH), go to IDLE.
- Simultaneous pending-set and consume in the same cycle: the flag ends up set. That edge counts for the next frame.
- gem_control is always 0.
- tkeep, tid and tdest are unused.

Test Plan:
- Reset: assert rst mid-XFER. All outputs go 0 immediately, state is IDLE, and frame_count=0.
- Normal frame: bytes 0x11,0x22,0x33 (tlast on 0x33, tuser=0), GEM pulses rd_request 3 times. Expect valid on each following cycle; sop with 0x11; eop with 0x33, err=0; ready drops after eop. Then toggle end_tog with status=0x5. Expect status_tog inverted, status_last=0x5, frame_done pulse, frame_count=1, ready returns once the next frame is present.
- Bad frame: 2-byte frame with tuser=1 on the last byte. Expect err=1 together with eop.
- Underflow: tvalid deasserted after the first byte while rd_request continues. Expect one cycle of valid=1 with underflow=1. Remaining bytes are drained with tready=1 and no valid; WAIT_END follows.
- Single-byte frame: sop, eop and valid all asserted in the same cycle.
- Early end toggle: end_tog toggles during XFER. The frame completes with no wait in WAIT_END, and frame_count increments once.
